status_reg: RTL
===============

# status_reg

Processor status register (P) for the 6502 core: the consumer end of the ALU flag interface and the source of the ALU's carry-in and decimal-mode inputs. Captures N/V/Z/C from ALU results under per-flag write enables. Applies explicit flag instructions (CLC/SEC/CLI/SEI/CLD/SED/CLV), BIT, PLP/RTI loads and interrupt entry. Provides the pushable P image and an IRQ mask with 6502-accurate one-instruction latency.

## Interface
- RESET_P, 8'h24: register value after reset; bit 5 is forced to 1 and bit 4 to 0 regardless of this value.
- clk  in  1  core clock; all state changes on rising edge
- reset  in  1  synchronous, active-high
- alu_flags  in  8  ALU flag vector; bit 7 = N, 6 = V, 1 = Z, 0 = C; other bits ignored
- alu_flags_we  in  4  per-flag update enables {N,V,Z,C} = bits [3:0]
- flag_op  in  3  000 none, 001 CLC, 010 SEC, 011 CLI, 100 SEI, 101 CLD, 110 SED, 111 CLV
- p_load  in  1  PLP/RTI: load p_din; bits 5 and 4 of p_din are ignored
- p_din  in  8  pulled status byte
- bit_load  in  1  BIT: N <= bit_operand[7], V <= bit_operand[6]
- bit_operand  in  8  memory operand of BIT
- int_entry  in  1  IRQ/NMI/BRK entry: set I
- push_brk  in  1  value of bit 4 in p_push (1 for BRK/PHP, 0 for IRQ/NMI)
- sync  in  1  instruction-boundary pulse (opcode fetch cycle)
- p_out  out  8  current P; bit 5 = 1, bit 4 = 0
- p_push  out  8  p_out with bit 4 = push_brk (combinational on push_brk only)
- alu_carry  out  1  C flag, to ALU carry-in
- alu_BCD  out  1  D flag, to ALU decimal mode
- irq_mask  out  1  I as seen by the IRQ poller

## Operation
- Storage: six flag flops N, V, D, I, Z, C, plus an irq_mask flop. Bits 5 and 4 are constants and have no storage.
- Per-flag next-state priority, highest first; if no source is active the flag holds:
  - C: p_load > CLC/SEC > alu_flags_we[0]
  - Z: p_load > alu_flags_we[1]
  - V: p_load > bit_load > CLV > alu_flags_we[2]
  - N: p_load > bit_load > alu_flags_we[3]
  - I: int_entry (sets 1) > p_load > CLI/SEI
  - D: p_load > CLD/SED
- Enables on different flags act independently in the same cycle. Example: bit_load with alu_flags_we = 4'b0010 updates N, V and Z together (full BIT).
- irq_mask:
  - On a cycle with sync = 1, irq_mask <= the current registered I.
  - On int_entry, irq_mask <= 1 at the same edge; this overrides sync.
  - Otherwise irq_mask holds.
  - Effect: CLI, SEI and PLP change the IRQ mask only after the next instruction boundary. This gives 6502 behaviour where one instruction executes after CLI before an IRQ is taken.
- flag_op values are mutually exclusive by encoding. Multiple asserted control strobes resolve purely by the priorities above; no error is reported.

## Timing
- All outputs except p_push are registered. Updates are visible the cycle after the strobe (1-cycle latency).
- alu_carry and alu_BCD are direct flop outputs, with no combinational path from any input. This avoids a loop through the combinational ALU.
- Reset values:
  - p_out = RESET_P with bit 5 = 1 and bit 4 = 0 (default 8'h24: I = 1, all other flags 0).
  - alu_carry = RESET_P[0], alu_BCD = RESET_P[3].
  - irq_mask = 1.
- Reset overrides every strobe in the same cycle. Reset mid-instruction discards pending updates; no partial update survives.
- Strobes are single-cycle. A strobe held for N cycles re-applies each cycle, which is idempotent for all sources.

## Test plan
- Reset: assert reset with p_load = 1, p_din = 8'hFF -> next cycle p_out = 8'h24, alu_carry = 0, alu_BCD = 0, irq_mask = 1.
- ALU capture: alu_flags = 8'hC3, alu_flags_we = 4'b1011 from P = 8'h24 -> p_out = 8'hA7 (V unchanged at 0), alu_carry = 1.
- Priority: same cycle alu_flags_we[0] = 1 with alu_flags[0] = 1 and flag_op = CLC -> C = 0. Same cycle bit_load with bit_operand = 8'h40 and flag_op = CLV -> V = 1, N = 0.
- PLP/push: p_load with p_din = 8'h1F -> p_out = 8'h2F. Then push_brk = 1 -> p_push = 8'h3F; push_brk = 0 -> p_push = 8'h2F.
- IRQ latency: from I = 1, CLI at cycle k -> p_out[2] = 0 at k+1, irq_mask still 1. sync at k+3 -> irq_mask = 0 at k+4. int_entry at k+5 -> I = 1 and irq_mask = 1 at k+6.
- Decimal: SED -> alu_BCD = 1 the next cycle. p_load with p_din = 8'h00 -> alu_BCD = 0 and I = 0, with irq_mask unchanged until the next sync.

Source files
------------

// File: rtl/status_reg.sv
// status_reg: 6502 processor status register (P).
// Holds the N, V, D, I, Z, C flags plus a separately timed IRQ mask.
// Bits 5 and 4 of P are constants (1 and 0) and have no storage; bit 4
// only exists in the pushed image, where it reflects push_brk.
// alu_carry and alu_BCD come straight from flops so the combinational
// ALU that consumes them cannot form a loop back through this block.
module status_reg #(
  parameter logic [7:0] RESET_P = 8'h24
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] alu_flags,
  input  logic [3:0] alu_flags_we,
  input  logic [2:0] flag_op,
  input  logic       p_load,
  input  logic [7:0] p_din,
  input  logic       bit_load,
  input  logic [7:0] bit_operand,
  input  logic       int_entry,
  input  logic       push_brk,
  input  logic       sync,
  output logic [7:0] p_out,
  output logic [7:0] p_push,
  output logic       alu_carry,
  output logic       alu_BCD,
  output logic       irq_mask
);

  // Explicit flag instruction encodings on flag_op.
  localparam logic [2:0] OP_NONE = 3'b000;
  localparam logic [2:0] OP_CLC  = 3'b001;
  localparam logic [2:0] OP_SEC  = 3'b010;
  localparam logic [2:0] OP_CLI  = 3'b011;
  localparam logic [2:0] OP_SEI  = 3'b100;
  localparam logic [2:0] OP_CLD  = 3'b101;
  localparam logic [2:0] OP_SED  = 3'b110;
  localparam logic [2:0] OP_CLV  = 3'b111;

  // Bit positions of each flag within the P byte.
  localparam int BIT_N = 7;
  localparam int BIT_V = 6;
  localparam int BIT_D = 3;
  localparam int BIT_I = 2;
  localparam int BIT_Z = 1;
  localparam int BIT_C = 0;

  // Flag storage.
  logic n_q, n_d;
  logic v_q, v_d;
  logic d_q, d_d;
  logic i_q, i_d;
  logic z_q, z_d;
  logic c_q, c_d;
  logic irq_mask_q, irq_mask_d;

  // Decoded flag instruction strobes.
  logic op_clc, op_sec, op_cli, op_sei, op_cld, op_sed, op_clv;

  // Inputs bits that carry no flag information.
  logic unused_bits;
  assign unused_bits = ^{alu_flags[5:2], p_din[5:4], bit_operand[5:0]};

  // Decode flag_op into one-hot instruction strobes.
  always_comb begin
    op_clc = 1'b0;
    op_sec = 1'b0;
    op_cli = 1'b0;
    op_sei = 1'b0;
    op_cld = 1'b0;
    op_sed = 1'b0;
    op_clv = 1'b0;
    case (flag_op)
      OP_NONE: ;
      OP_CLC:  op_clc = 1'b1;
      OP_SEC:  op_sec = 1'b1;
      OP_CLI:  op_cli = 1'b1;
      OP_SEI:  op_sei = 1'b1;
      OP_CLD:  op_cld = 1'b1;
      OP_SED:  op_sed = 1'b1;
      OP_CLV:  op_clv = 1'b1;
      default: ;
    endcase
  end

  // Carry: pulled byte beats CLC/SEC, which beat the ALU.
  always_comb begin
    c_d = c_q;
    if (p_load) begin
      c_d = p_din[BIT_C];
    end else if (op_clc) begin
      c_d = 1'b0;
    end else if (op_sec) begin
      c_d = 1'b1;
    end else if (alu_flags_we[0]) begin
      c_d = alu_flags[BIT_C];
    end
  end

  // Zero: pulled byte beats the ALU.
  always_comb begin
    z_d = z_q;
    if (p_load) begin
      z_d = p_din[BIT_Z];
    end else if (alu_flags_we[1]) begin
      z_d = alu_flags[BIT_Z];
    end
  end

  // Overflow: pulled byte, then BIT operand, then CLV, then the ALU.
  always_comb begin
    v_d = v_q;
    if (p_load) begin
      v_d = p_din[BIT_V];
    end else if (bit_load) begin
      v_d = bit_operand[6];
    end else if (op_clv) begin
      v_d = 1'b0;
    end else if (alu_flags_we[2]) begin
      v_d = alu_flags[BIT_V];
    end
  end

  // Negative: pulled byte, then BIT operand, then the ALU.
  always_comb begin
    n_d = n_q;
    if (p_load) begin
      n_d = p_din[BIT_N];
    end else if (bit_load) begin
      n_d = bit_operand[7];
    end else if (alu_flags_we[3]) begin
      n_d = alu_flags[BIT_N];
    end
  end

  // Interrupt disable: interrupt entry always wins so a handler can never
  // start with I clear, even if a pull happens in the same cycle.
  always_comb begin
    i_d = i_q;
    if (int_entry) begin
      i_d = 1'b1;
    end else if (p_load) begin
      i_d = p_din[BIT_I];
    end else if (op_cli) begin
      i_d = 1'b0;
    end else if (op_sei) begin
      i_d = 1'b1;
    end
  end

  // Decimal mode: pulled byte beats CLD/SED.
  always_comb begin
    d_d = d_q;
    if (p_load) begin
      d_d = p_din[BIT_D];
    end else if (op_cld) begin
      d_d = 1'b0;
    end else if (op_sed) begin
      d_d = 1'b1;
    end
  end

  // IRQ mask samples the registered I only at instruction boundaries, so a
  // change to I takes effect one instruction late; interrupt entry masks
  // immediately.
  always_comb begin
    irq_mask_d = irq_mask_q;
    if (int_entry) begin
      irq_mask_d = 1'b1;
    end else if (sync) begin
      irq_mask_d = i_q;
    end
  end

  // Flag and mask registers; reset discards every strobe in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      n_q        <= RESET_P[BIT_N];
      v_q        <= RESET_P[BIT_V];
      d_q        <= RESET_P[BIT_D];
      i_q        <= RESET_P[BIT_I];
      z_q        <= RESET_P[BIT_Z];
      c_q        <= RESET_P[BIT_C];
      irq_mask_q <= 1'b1;
    end else begin
      n_q        <= n_d;
      v_q        <= v_d;
      d_q        <= d_d;
      i_q        <= i_d;
      z_q        <= z_d;
      c_q        <= c_d;
      irq_mask_q <= irq_mask_d;
    end
  end

  // Assemble the visible P byte and the pushed image.
  always_comb begin
    p_out  = {n_q, v_q, 1'b1, 1'b0, d_q, i_q, z_q, c_q};
    p_push = {n_q, v_q, 1'b1, push_brk, d_q, i_q, z_q, c_q};
  end

  assign alu_carry = c_q;
  assign alu_BCD   = d_q;
  assign irq_mask  = irq_mask_q;

endmodule
